// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter: round-robin arbiter giving an instruction master and a data master access to one Avalon-MM slave.
// Define ARB_TIMEOUT_EN to abort transfers on a slave that never drops waitrequest.
module avalon_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   i_address,
   input  logic                i_read,
   output logic                i_waitrequest,
   output logic [DATA_W-1:0]   i_readdata,
   input  logic [ADDR_W-1:0]   d_address,
   input  logic [DATA_W/8-1:0] d_byteenable,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [DATA_W-1:0]   d_writedata,
   output logic                d_waitrequest,
   output logic [DATA_W-1:0]   d_readdata,
   output logic [ADDR_W-1:0]   s_address,
   output logic [DATA_W/8-1:0] s_byteenable,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   output logic [1:0]          owner,
   output logic                protocol_err,
   output logic                timeout_err
);
   typedef enum logic [1:0] {IDLE = 2'b00, BUSY_I = 2'b01, BUSY_D = 2'b10} state_t;
   state_t state;
   logic last_d, busy_i, busy_d, req_i, req_d, strobe, to;
   assign busy_i = state == BUSY_I;
   assign busy_d = state == BUSY_D;
   assign req_i = i_read;
   assign req_d = d_read | d_write;
   assign strobe = busy_i ? req_i : busy_d & req_d;
   assign owner = state;
   assign s_address = busy_d ? d_address : i_address;
   assign s_byteenable = busy_d ? d_byteenable : '1;
   assign s_writedata = d_writedata;
   assign s_write = busy_d & d_write & ~to;
   // a simultaneous read+write is issued as the write
   assign s_read = ~to & (busy_i ? i_read : busy_d & d_read & ~d_write);
   assign i_waitrequest = ~busy_i | (s_waitrequest & ~to);
   assign d_waitrequest = ~busy_d | (s_waitrequest & ~to);
   assign i_readdata = to ? '0 : s_readdata;
   assign d_readdata = i_readdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         last_d <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         protocol_err <= protocol_err | (d_read & d_write);
         if (state == IDLE)
            state <= req_i & req_d ? (last_d ? BUSY_I : BUSY_D) : req_d ? BUSY_D : req_i ? BUSY_I : IDLE;
         else if (to || !strobe)
            state <= IDLE;
         else if (!s_waitrequest) begin
            state <= IDLE;
            last_d <= busy_d;
         end
      end
`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt;
   assign to = state != IDLE && cnt == CW'(TIMEOUT_CYCLES);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         timeout_err <= 1'b0;
      end else begin
         cnt <= state == IDLE ? '0 : cnt + CW'(s_waitrequest & ~to);
         timeout_err <= timeout_err | to;
      end
`else
   assign to = 1'b0;
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// tb_avalon_mem_arbiter: directed and randomized checks of the arbiter against a transfer-level model.
module tb_avalon_mem_arbiter;
   localparam int TC = 8;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b1;
   logic [31:0] i_address, d_address, d_writedata, s_readdata;
   logic [3:0] d_byteenable;
   logic i_read, d_read, d_write, s_waitrequest;
   logic i_waitrequest, d_waitrequest, s_read, s_write, protocol_err, timeout_err;
   logic [31:0] i_readdata, d_readdata, s_address, s_writedata;
   logic [3:0] s_byteenable;
   logic [1:0] owner;
   int n_tests = 0, n_fail = 0;
   int m_own, m_cnt;
   bit m_last_d, m_perr, m_terr;

   always #5 clk = ~clk;

   avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
      .d_address(d_address), .d_byteenable(d_byteenable), .d_read(d_read), .d_write(d_write),
      .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .owner(owner), .protocol_err(protocol_err), .timeout_err(timeout_err)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_to();
      return TO_EN && m_own != 0 && m_cnt == TC;
   endfunction

   // model: who owns the slave, whose turn a tie is, sticky errors, stall count
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_own <= 0; m_cnt <= 0; m_last_d <= 0; m_perr <= 0; m_terr <= 0;
      end else begin
         m_perr <= m_perr | (d_read & d_write);
         if (m_own == 0) begin
            m_cnt <= 0;
            if (i_read && (d_read || d_write)) m_own <= m_last_d ? 1 : 2;
            else if (d_read || d_write) m_own <= 2;
            else if (i_read) m_own <= 1;
         end else if (m_to()) begin
            m_own <= 0; m_terr <= 1; m_cnt <= 0;
         end else if (!(m_own == 1 ? i_read : (d_read || d_write))) begin
            m_own <= 0; m_cnt <= 0;
         end else if (!s_waitrequest) begin
            m_own <= 0; m_last_d <= m_own == 2; m_cnt <= 0;
         end else
            m_cnt <= m_cnt + 1;
      end

   always @(negedge clk) begin
      bit t;
      t = m_to();
      chk("owner", owner, m_own);
      chk("s_read", s_read, !t && (m_own == 1 ? i_read : (m_own == 2 && d_read && !d_write)));
      chk("s_write", s_write, !t && m_own == 2 && d_write);
      chk("i_waitrequest", i_waitrequest, m_own == 1 ? (!t && s_waitrequest) : 1'b1);
      chk("d_waitrequest", d_waitrequest, m_own == 2 ? (!t && s_waitrequest) : 1'b1);
      chk("i_readdata", i_readdata, t ? 32'h0 : s_readdata);
      chk("d_readdata", d_readdata, t ? 32'h0 : s_readdata);
      chk("protocol_err", protocol_err, m_perr);
      chk("timeout_err", timeout_err, m_terr);
      if (m_own == 1) begin
         chk("s_address_i", s_address, i_address);
         chk("s_byteenable_i", s_byteenable, 4'hf);
      end
      if (m_own == 2) begin
         chk("s_address_d", s_address, d_address);
         chk("s_byteenable_d", s_byteenable, d_byteenable);
         chk("s_writedata", s_writedata, d_writedata);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      {i_read, d_read, d_write, s_waitrequest} = '0;
      i_address = '0; d_address = '0; d_byteenable = '0; d_writedata = '0; s_readdata = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_owner", owner, 2'b00);
      chk("rst_s_read", s_read, 1'b0);
      chk("rst_s_write", s_write, 1'b0);
      chk("rst_i_wait", i_waitrequest, 1'b1);
      chk("rst_d_wait", d_waitrequest, 1'b1);
      chk("rst_perr", protocol_err, 1'b0);
      chk("rst_terr", timeout_err, 1'b0);
      step(); step();
      rst_n = 1'b1;
      // instruction read with three stall cycles
      i_address = 32'h100; i_read = 1; s_waitrequest = 1;
      @(negedge clk);
      chk("lat_owner", owner, 2'b00);
      chk("lat_s_read", s_read, 1'b0);
      step();
      @(negedge clk);
      chk("ird_owner", owner, 2'b01);
      chk("ird_s_read", s_read, 1'b1);
      chk("ird_addr", s_address, 32'h100);
      chk("ird_wait", i_waitrequest, 1'b1);
      repeat (3) step();
      s_waitrequest = 0; s_readdata = 32'h1234_5678;
      @(negedge clk);
      chk("ird_done_wait", i_waitrequest, 1'b0);
      chk("ird_rdata", i_readdata, 32'h1234_5678);
      step();
      i_read = 0; s_waitrequest = 1;
      @(negedge clk);
      chk("ird_release", owner, 2'b00);
      // ties: data first after an instruction transfer, then alternation
      i_read = 1; d_read = 1; d_address = 32'h200; s_waitrequest = 0;
      step();
      @(negedge clk); chk("tie1_first", owner, 2'b10);
      step();
      @(negedge clk); chk("tie1_bubble", owner, 2'b00);
      step();
      @(negedge clk); chk("tie1_second", owner, 2'b01);
      step();
      i_read = 0;
      step();
      @(negedge clk); chk("d_alone", owner, 2'b10);
      step();
      i_read = 1;
      step();
      @(negedge clk); chk("tie2_first", owner, 2'b01);
      step();
      i_read = 0; d_read = 0;
      // byte-lane write while instruction master waits
      d_write = 1; d_byteenable = 4'h3; d_writedata = 32'hCAFE_BABE; d_address = 32'h300;
      i_read = 1; s_waitrequest = 1;
      step();
      @(negedge clk);
      chk("wr_owner", owner, 2'b10);
      chk("wr_s_write", s_write, 1'b1);
      chk("wr_be", s_byteenable, 4'h3);
      chk("wr_data", s_writedata, 32'hCAFE_BABE);
      chk("wr_i_wait", i_waitrequest, 1'b1);
      step();
      s_waitrequest = 0;
      @(negedge clk);
      chk("wr_d_wait", d_waitrequest, 1'b0);
      chk("wr_i_wait2", i_waitrequest, 1'b1);
      step();
      d_write = 0; i_read = 0; s_waitrequest = 1;
      step();
      // read and write together
      d_read = 1; d_write = 1; s_waitrequest = 0;
      step();
      @(negedge clk);
      chk("rw_s_write", s_write, 1'b1);
      chk("rw_s_read", s_read, 1'b0);
      chk("rw_perr", protocol_err, 1'b1);
      step();
      d_read = 0; d_write = 0;
      step();
      @(negedge clk); chk("rw_perr_sticky", protocol_err, 1'b1);
      // asynchronous reset during a stalled write
      d_write = 1; s_waitrequest = 1;
      step();
      @(negedge clk); chk("ar_owner_busy", owner, 2'b10);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("ar_s_write", s_write, 1'b0);
      chk("ar_owner", owner, 2'b00);
      chk("ar_d_wait", d_waitrequest, 1'b1);
      chk("ar_perr", protocol_err, 1'b0);
      step();
      rst_n = 1'b1;
      @(negedge clk); chk("ar_idle", owner, 2'b00);
      step();
      @(negedge clk); chk("ar_regrant", owner, 2'b10);
      d_write = 0;
      step();
      // hung slave
      d_read = 1; s_readdata = 32'hFFFF_FFFF;
      step();
      @(negedge clk); chk("hang_owner", owner, 2'b10);
      repeat (TC) step();
      @(negedge clk);
`ifdef ARB_TIMEOUT_EN
      chk("to_d_wait", d_waitrequest, 1'b0);
      chk("to_rdata", d_readdata, 32'h0);
      chk("to_s_read", s_read, 1'b0);
      step();
      @(negedge clk);
      chk("to_terr", timeout_err, 1'b1);
      chk("to_owner", owner, 2'b00);
`else
      chk("hold_d_wait", d_waitrequest, 1'b1);
      chk("hold_s_read", s_read, 1'b1);
      step();
      @(negedge clk);
      chk("hold_terr", timeout_err, 1'b0);
      chk("hold_owner", owner, 2'b10);
`endif
      d_read = 0; s_waitrequest = 0;
      step();
      for (int c = 0; c < 3000; c++) begin
         i_read = $urandom_range(0, 3) != 0;
         d_read = $urandom_range(0, 2) == 0;
         d_write = $urandom_range(0, 3) == 0;
         i_address = $urandom; d_address = $urandom;
         d_byteenable = 4'($urandom); d_writedata = $urandom; s_readdata = $urandom;
         s_waitrequest = ((c / 50) % 4 == 3) ? 1'b1 : ($urandom_range(0, 2) == 0);
         step();
      end
      {i_read, d_read, d_write} = '0;
      step(); step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
